// File: rtl/hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared constants for the decode-side hazard scoreboard:
//   register file geometry, the link register used by JAL/JALR, the tracked
//   pipeline depth and stage indices, and the default stall counter width.
//   No ports; imported by the interface, the stage flop and the top.
// ----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int DEF_REG_W    = 3;
    localparam int DEF_NUM_REGS = 2 ** DEF_REG_W;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_CNT_W    = 16;

    // JAL/JALR write their return address here.
    localparam logic [DEF_REG_W-1:0] LINK_REG = 3'd7;

    // Tracked stages after ID, youngest first.
    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Decode register-specifier interface.
//   master (decode): drives id_valid, id_rs1/_en, id_rs2/_en, id_rd/_en, flush;
//                    receives stall and pending_mask.
//   slave (scoreboard): the mirror image.
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
);
    logic                  id_valid;
    logic [REG_W-1:0]      id_rs1;
    logic                  id_rs1_en;
    logic [REG_W-1:0]      id_rs2;
    logic                  id_rs2_en;
    logic [REG_W-1:0]      id_rd;
    logic                  id_rd_en;
    logic                  flush;
    logic                  stall;
    logic [2**REG_W-1:0]   pending_mask;

    modport master (
        output id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en,
               id_rd, id_rd_en, flush,
        input  stall, pending_mask
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en,
               id_rd, id_rd_en, flush,
        output stall, pending_mask
    );

endinterface

// File: rtl/hazard_scoreboard_stage.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_stage
//   One tracked pipeline stage: a {v, rd} flop plus two source-specifier
//   compares (one per ID read port).
//   Ports: clk, rst (async, active high); in_v/in_rd = entry from the younger
//   stage (or the ID load for stage 0); rs1/rs2 = ID source specifiers;
//   v/rd = held entry; hit1/hit2 = valid entry whose rd equals rs1/rs2.
// ----------------------------------------------------------------------------
module hazard_scoreboard_stage
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             v,
    output logic [REG_W-1:0] rd,
    output logic             hit1,
    output logic             hit2
);

    logic             v_r;
    logic [REG_W-1:0] rd_r;

    // Entry register: advances every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r  <= 1'b0;
            rd_r <= {REG_W{1'b0}};
        end else begin
            v_r  <= in_v;
            rd_r <= in_rd;
        end
    end

    assign v    = v_r;
    assign rd   = rd_r;
    assign hit1 = v_r & (rd_r == rs1);
    assign hit2 = v_r & (rd_r == rs2);

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Consumer end of the decode register-specifier interface. Tracks in-flight
//   destination writes through EX/MEM/WB and raises stall when an ID source
//   reads a register that is still waiting for writeback (no forwarding).
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     sb          hazard_scoreboard_if.slave (ID specifiers, flush, stall,
//                 pending_mask)
//     stall_cnt   saturating count of stalled cycles
//   Parameters: REG_W, DEPTH, RF_BYPASS (WB match ignored when 1), CNT_W.
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W     = DEF_REG_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   sb,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int NUM_REGS = 2 ** REG_W;

    // Stages that can still hold a value the regfile has not delivered.
    // With write-before-read, the WB stage is already visible to ID.
    localparam logic [DEPTH-1:0] COUNT_MASK =
        (RF_BYPASS != 0) ? {1'b0, {(DEPTH-1){1'b1}}} : {DEPTH{1'b1}};

    logic [DEPTH-1:0]            v_s;
    logic [DEPTH-1:0][REG_W-1:0] rd_s;
    logic [DEPTH-1:0]            hit1_s;
    logic [DEPTH-1:0]            hit2_s;
    logic                        match1_s;
    logic                        match2_s;
    logic                        stall_s;
    logic                        load_v_s;
    logic [NUM_REGS-1:0]         mask_s;
    logic [CNT_W-1:0]            stall_cnt_r;

    // Stage chain: stage 0 takes the ID instruction, later stages shift.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            hazard_scoreboard_stage #(.REG_W(REG_W)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .in_v  (load_v_s),
                .in_rd (sb.id_rd),
                .rs1   (sb.id_rs1),
                .rs2   (sb.id_rs2),
                .v     (v_s[g]),
                .rd    (rd_s[g]),
                .hit1  (hit1_s[g]),
                .hit2  (hit2_s[g])
            );
        end else begin : g_tail
            hazard_scoreboard_stage #(.REG_W(REG_W)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .in_v  (v_s[g-1]),
                .in_rd (rd_s[g-1]),
                .rs1   (sb.id_rs1),
                .rs2   (sb.id_rs2),
                .v     (v_s[g]),
                .rd    (rd_s[g]),
                .hit1  (hit1_s[g]),
                .hit2  (hit2_s[g])
            );
        end
    end

    // Stall OR-tree. The ID instruction is not yet in the chain, so it can
    // never match its own rd; rs1==rs2 collapses into a single stall term.
    always_comb begin
        match1_s = |(hit1_s & COUNT_MASK);
        match2_s = |(hit2_s & COUNT_MASK);
        stall_s  = ~rst & sb.id_valid & ~sb.flush &
                   ((sb.id_rs1_en & match1_s) | (sb.id_rs2_en & match2_s));
        // A stalled or flushed instruction enters EX as a bubble.
        load_v_s = sb.id_valid & sb.id_rd_en & ~sb.flush & ~stall_s;
    end

    // Pending-write mask covers every tracked stage, including WB.
    always_comb begin
        mask_s = {NUM_REGS{1'b0}};
        for (int s = 0; s < DEPTH; s++) begin
            mask_s = mask_s | ({{(NUM_REGS-1){1'b0}}, v_s[s]} << rd_s[s]);
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign sb.stall        = stall_s;
    assign sb.pending_mask = mask_s;
    assign stall_cnt       = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Two scoreboards driven with identical decode traffic: dut_a uses
//   RF_BYPASS=1 with a 16-bit counter, dut_b uses RF_BYPASS=0 with a 4-bit
//   counter so saturation is reachable quickly. A behavioural model predicts
//   stall/pending_mask/stall_cnt each cycle; predictions are queued when the
//   inputs are driven and popped when the outputs are sampled.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int RW   = 3;
    localparam int NR   = 8;
    localparam int CW_A = 16;
    localparam int CW_B = 4;

    logic            clk;
    logic            rst;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    logic            d_valid, d_rs1_en, d_rs2_en, d_rd_en, d_flush;
    logic [RW-1:0]   d_rs1, d_rs2, d_rd;

    hazard_scoreboard_if #(.REG_W(RW)) bus_a ();
    hazard_scoreboard_if #(.REG_W(RW)) bus_b ();

    assign bus_a.id_valid  = d_valid;
    assign bus_a.id_rs1    = d_rs1;
    assign bus_a.id_rs1_en = d_rs1_en;
    assign bus_a.id_rs2    = d_rs2;
    assign bus_a.id_rs2_en = d_rs2_en;
    assign bus_a.id_rd     = d_rd;
    assign bus_a.id_rd_en  = d_rd_en;
    assign bus_a.flush     = d_flush;
    assign bus_b.id_valid  = d_valid;
    assign bus_b.id_rs1    = d_rs1;
    assign bus_b.id_rs1_en = d_rs1_en;
    assign bus_b.id_rs2    = d_rs2;
    assign bus_b.id_rs2_en = d_rs2_en;
    assign bus_b.id_rd     = d_rd;
    assign bus_b.id_rd_en  = d_rd_en;
    assign bus_b.flush     = d_flush;

    hazard_scoreboard #(.REG_W(RW), .DEPTH(3), .RF_BYPASS(1), .CNT_W(CW_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .sb        (bus_a.slave),
        .stall_cnt (cnt_a)
    );

    hazard_scoreboard #(.REG_W(RW), .DEPTH(3), .RF_BYPASS(0), .CNT_W(CW_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .sb        (bus_b.slave),
        .stall_cnt (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) --------
    logic          m_v   [2][3];
    logic [RW-1:0] m_rd  [2][3];
    int unsigned   m_cnt [2];
    int unsigned   m_max [2];

    typedef struct {
        logic          stall;
        logic [NR-1:0] mask;
        int unsigned   cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks;
    int failures;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_match(input int i, input logic [RW-1:0] r);
        int   last;
        logic hit;
        last = (i == 0) ? 1 : 2;   // dut_a ignores the WB stage
        hit  = 1'b0;
        for (int s = 0; s <= last; s++)
            if (m_v[i][s] && (m_rd[i][s] == r)) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic m_stall(input int i);
        return d_valid && !d_flush &&
               ((d_rs1_en && m_match(i, d_rs1)) || (d_rs2_en && m_match(i, d_rs2)));
    endfunction

    function automatic logic [NR-1:0] m_mask(input int i);
        logic [NR-1:0] m;
        m = '0;
        for (int s = 0; s < 3; s++)
            if (m_v[i][s]) m[m_rd[i][s]] = 1'b1;
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) begin
                m_v[i][s]  = 1'b0;
                m_rd[i][s] = '0;
            end
            m_cnt[i] = 0;
        end
    endtask

    task automatic m_clock();
        logic st;
        for (int i = 0; i < 2; i++) begin
            st = m_stall(i);
            if (st && (m_cnt[i] < m_max[i])) m_cnt[i] = m_cnt[i] + 1;
            m_v[i][2]  = m_v[i][1];  m_rd[i][2] = m_rd[i][1];
            m_v[i][1]  = m_v[i][0];  m_rd[i][1] = m_rd[i][0];
            m_v[i][0]  = d_valid && d_rd_en && !d_flush && !st;
            m_rd[i][0] = d_rd;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.stall = m_stall(0); e.mask = m_mask(0); e.cnt = m_cnt[0];
        q_a.push_back(e);
        e.stall = m_stall(1); e.mask = m_mask(1); e.cnt = m_cnt[1];
        q_b.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = q_a.pop_front();
        check_eq({tag, "_a_stall"}, 32'(bus_a.stall), 32'(e.stall));
        check_eq({tag, "_a_mask"},  32'(bus_a.pending_mask), 32'(e.mask));
        check_eq({tag, "_a_cnt"},   32'(cnt_a), e.cnt);
        e = q_b.pop_front();
        check_eq({tag, "_b_stall"}, 32'(bus_b.stall), 32'(e.stall));
        check_eq({tag, "_b_mask"},  32'(bus_b.pending_mask), 32'(e.mask));
        check_eq({tag, "_b_cnt"},   32'(cnt_b), e.cnt);
    endtask

    task automatic set_in(input logic v, input logic [RW-1:0] r1, input logic e1,
                          input logic [RW-1:0] r2, input logic e2,
                          input logic [RW-1:0] rd, input logic rde, input logic fl);
        d_valid = v;  d_rs1 = r1; d_rs1_en = e1; d_rs2 = r2; d_rs2_en = e2;
        d_rd = rd;    d_rd_en = rde; d_flush = fl;
    endtask

    // One ID cycle: drive on the falling edge, check 1ns later, clock model.
    task automatic step(input string tag, input logic v, input logic [RW-1:0] r1, input logic e1,
                        input logic [RW-1:0] r2, input logic e2,
                        input logic [RW-1:0] rd, input logic rde, input logic fl);
        @(negedge clk);
        set_in(v, r1, e1, r2, e2, rd, rde, fl);
        push_exp();
        #1;
        compare(tag);
        @(posedge clk);
        m_clock();
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        m_reset();
        push_exp();
        #1;
        compare(tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_max[0] = 32'd65535;
        m_max[1] = 32'd15;
        rst      = 1'b0;
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

        // 1. reset state, quiet inputs
        do_reset("t1_rst");
        check_eq("t1_cnt_a0", 32'(cnt_a), 32'd0);
        for (int k = 0; k < 3; k++) idle("t1_idle");

        // 2/3. ADD R3<-R1,R2 then ADDI R4<-R3 held in ID
        do_reset("t2_rst");
        step("t2_add", 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            step("t2_addi", 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        idle("t2_idle");
        #1;
        check_eq("t2_cnt_bypass",   32'(cnt_a), 32'd2);
        check_eq("t3_cnt_nobypass", 32'(cnt_b), 32'd3);

        // 4. JAL then JR R7
        do_reset("t4_rst");
        step("t4_jal", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, LINK_REG, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            step("t4_jr", 1'b1, LINK_REG, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle("t4_idle");
        #1;
        check_eq("t4_cnt_a", 32'(cnt_a), 32'd2);
        check_eq("t4_cnt_b", 32'(cnt_b), 32'd3);

        // 4b. flushed dependent: no stall, enters as bubble
        do_reset("t4f_rst");
        step("t4f_jal", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, LINK_REG, 1'b1, 1'b0);
        step("t4f_flush", 1'b1, LINK_REG, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        #1;
        check_eq("t4f_bubble_mask", 32'(bus_a.pending_mask), 32'h80);
        idle("t4f_idle");

        // 5. rs1==rs2 on one pending rd
        do_reset("t5_rst");
        step("t5_wr5", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            step("t5_st", 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
        idle("t5_idle");
        #1;
        check_eq("t5_single_cnt", 32'(cnt_a), 32'd2);

        // 5b. unused rs2=R0 while R0 is pending; 5c. self-dependence
        do_reset("t5b_rst");
        step("t5b_wr0", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        step("t5b_rs2off", 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        step("t5c_self", 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0);
        idle("t5c_idle");
        #1;
        check_eq("t5b_no_stall_cnt", 32'(cnt_a), 32'd0);

        // random traffic
        do_reset("rnd_rst");
        for (int k = 0; k < 60; k++)
            step("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));

        // 6. saturate dut_b counter with back-to-back R1<-R1 dependents
        do_reset("t6_rst");
        for (int k = 0; k < 32; k++)
            step("t6_sat", 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) idle("t6_drain");
        #1;
        check_eq("t6_cnt_sat", 32'(cnt_b), 32'hF);
        step("t6_wr6", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        @(negedge clk);
        set_in(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp();
        #1;
        compare("t6_pre_rst");
        check_eq("t6_stall_before_rst", 32'(bus_a.stall), 32'd1);
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        check_eq("t6_rst_stall_a", 32'(bus_a.stall), 32'd0);
        check_eq("t6_rst_mask_a",  32'(bus_a.pending_mask), 32'd0);
        check_eq("t6_rst_stall_b", 32'(bus_b.stall), 32'd0);
        check_eq("t6_rst_mask_b",  32'(bus_b.pending_mask), 32'd0);
        check_eq("t6_rst_cnt_b",   32'(cnt_b), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
